// File: rtl/vx_dispatch_multi.sv
// vx_dispatch_multi: routes NUM_INPUTS issue slices into NUM_UNITS per-unit FIFOs, with one round-robin arbiter per unit.
// Latency: an accepted entry becomes visible on out_valid/out_data on the next clk edge at the earliest.
// Backpressure: in_ready[i] is high only when input i is granted by its unit and that unit's FIFO is not full.
//               in_ready does not depend on out_ready, so a full FIFO refuses a push even in a cycle where it pops.
//
// Ports:
//   clk, reset                 single clock; asynchronous active-high reset
//   in_valid/in_data/in_tmask  per-input request, payload and thread mask
//   in_ex_type                 per-input target unit index
//   in_ready                   per-input accept strobe
//   out_valid/out_data         per-unit head entry; out_data holds {payload, last_tid}
//   out_ready                  per-unit consumer ready
//   out_count                  per-unit FIFO occupancy
//   perf_stalls                per-unit stall counters, present only when DISPATCH_PERF_EN is defined
module vx_dispatch_multi #(
    parameter int NUM_INPUTS    = 2,
    parameter int NUM_UNITS     = 4,
    parameter int DATAW         = 64,
    parameter int NUM_THREADS   = 4,
    parameter int BUF_DEPTH     = 2,
    parameter int PERF_CTR_BITS = 44,
    localparam int NT_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int EX_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int IN_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int CNT_W = $clog2(BUF_DEPTH + 1),
    localparam int OUT_W = DATAW + NT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_INPUTS-1:0]          in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0]    in_data,
    input  logic [NUM_INPUTS*NUM_THREADS-1:0] in_tmask,
    input  logic [NUM_INPUTS*EX_W-1:0]     in_ex_type,
    output logic [NUM_INPUTS-1:0]          in_ready,
    output logic [NUM_UNITS-1:0]           out_valid,
    output logic [NUM_UNITS*OUT_W-1:0]     out_data,
    input  logic [NUM_UNITS-1:0]           out_ready,
    output logic [NUM_UNITS*CNT_W-1:0]     out_count
`ifdef DISPATCH_PERF_EN
    ,
    output logic [NUM_UNITS*PERF_CTR_BITS-1:0] perf_stalls
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [OUT_W-1:0] r_mem    [NUM_UNITS][BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr [NUM_UNITS];
    logic [PTR_W-1:0] r_wr_ptr [NUM_UNITS];
    logic [CNT_W-1:0] r_count  [NUM_UNITS];
    logic [IN_W-1:0]  r_rr_ptr [NUM_UNITS];

    logic [EX_W-1:0]      w_ex        [NUM_INPUTS];
    logic [OUT_W-1:0]     w_in_entry  [NUM_INPUTS];
    logic [IN_W-1:0]      w_grant_idx [NUM_UNITS];
    logic [OUT_W-1:0]     w_push_dat  [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_grant_vld;
    logic [NUM_UNITS-1:0] w_full;
    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;

    // Index of the highest set thread bit; an empty mask maps to thread 0.
    function automatic logic [NT_W-1:0] f_last_tid(input logic [NUM_THREADS-1:0] mask);
        logic [NT_W-1:0] tid;
        tid = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (mask[t]) tid = NT_W'(t);
        end
        return tid;
    endfunction

    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_ex[i]       = in_ex_type[i*EX_W +: EX_W];
            w_in_entry[i] = {in_data[i*DATAW +: DATAW],
                             f_last_tid(in_tmask[i*NUM_THREADS +: NUM_THREADS])};
        end
    end

    // Per-unit round-robin: scan inputs starting at the unit's pointer, first requester wins.
    always_comb begin
        int v_idx;
        v_idx = 0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            w_grant_vld[u] = 1'b0;
            w_grant_idx[u] = '0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                v_idx = (int'(r_rr_ptr[u]) + k) % NUM_INPUTS;
                if (!w_grant_vld[u] && in_valid[v_idx] && (int'(w_ex[v_idx]) == u)) begin
                    w_grant_vld[u] = 1'b1;
                    w_grant_idx[u] = IN_W'(v_idx);
                end
            end
            w_full[u]     = (r_count[u] == CNT_W'(BUF_DEPTH));
            w_push[u]     = w_grant_vld[u] && !w_full[u] && !reset;
            w_pop[u]      = (r_count[u] != '0) && out_ready[u];
            w_push_dat[u] = w_in_entry[w_grant_idx[u]];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = 1'b0;
            if (int'(w_ex[i]) < NUM_UNITS) begin
                in_ready[i] = w_push[w_ex[i]] && (w_grant_idx[w_ex[i]] == IN_W'(i));
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        out_count = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            out_valid[u]                  = (r_count[u] != '0);
            out_data[u*OUT_W +: OUT_W]    = r_mem[u][r_rd_ptr[u]];
            out_count[u*CNT_W +: CNT_W]   = r_count[u];
        end
    end

    // Storage is not reset: out_valid qualifies it, and the pointers restart at 0.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_push[u]) r_mem[u][r_wr_ptr[u]] <= w_push_dat[u];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_rd_ptr[u] <= '0;
                r_wr_ptr[u] <= '0;
                r_count[u]  <= '0;
                r_rr_ptr[u] <= '0;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_push[u]) begin
                    r_wr_ptr[u] <= f_ptr_inc(r_wr_ptr[u]);
                    r_rr_ptr[u] <= IN_W'((int'(w_grant_idx[u]) + 1) % NUM_INPUTS);
                end
                if (w_pop[u]) r_rd_ptr[u] <= f_ptr_inc(r_rd_ptr[u]);
                case ({w_push[u], w_pop[u]})
                    2'b10:   r_count[u] <= r_count[u] + 1'b1;
                    2'b01:   r_count[u] <= r_count[u] - 1'b1;
                    default: r_count[u] <= r_count[u];
                endcase
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [PERF_CTR_BITS-1:0] r_perf  [NUM_UNITS];
    logic [NUM_UNITS-1:0]     w_stall;

    // A unit stalls in any cycle where some input aimed at it is valid but not accepted.
    always_comb begin
        w_stall = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_valid[i] && !in_ready[i] && (int'(w_ex[i]) < NUM_UNITS)) begin
                w_stall[w_ex[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) r_perf[u] <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_stall[u]) r_perf[u] <= r_perf[u] + 1'b1;
            end
        end
    end

    always_comb begin
        perf_stalls = '0;
        for (int u = 0; u < NUM_UNITS; u++) perf_stalls[u*PERF_CTR_BITS +: PERF_CTR_BITS] = r_perf[u];
    end
`else
    // No stall counters are built in this configuration.
`endif

endmodule

// File: tb/tb_vx_dispatch_multi.sv
// tb_vx_dispatch_multi: directed bench for vx_dispatch_multi with a scoreboard of expected FIFO entries.
// Inputs are driven on the falling edge; transfers and outputs are sampled 1 ns later, ahead of the rising edge.
// Every accepted entry is modelled by the bench and compared when the unit pops it.
module tb_vx_dispatch_multi;

    localparam int NI  = 2;
    localparam int NU  = 4;
    localparam int DW  = 64;
    localparam int NT  = 4;
    localparam int BD  = 2;
    localparam int PCB = 44;
    localparam int NTW = 2;
    localparam int EXW = 2;
    localparam int CW  = 2;
    localparam int OW  = DW + NTW;

    logic              clk;
    logic              reset;
    logic [NI-1:0]     in_valid;
    logic [NI*DW-1:0]  in_data;
    logic [NI*NT-1:0]  in_tmask;
    logic [NI*EXW-1:0] in_ex_type;
    logic [NI-1:0]     in_ready;
    logic [NU-1:0]     out_valid;
    logic [NU*OW-1:0]  out_data;
    logic [NU-1:0]     out_ready;
    logic [NU*CW-1:0]  out_count;
`ifdef DISPATCH_PERF_EN
    logic [NU*PCB-1:0] perf_stalls;
`endif

    vx_dispatch_multi #(
        .NUM_INPUTS(NI), .NUM_UNITS(NU), .DATAW(DW), .NUM_THREADS(NT),
        .BUF_DEPTH(BD), .PERF_CTR_BITS(PCB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_tmask(in_tmask),
        .in_ex_type(in_ex_type),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .out_count(out_count)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_stalls(perf_stalls)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int            unit;
        logic [OW-1:0] dat;
    } sb_t;

    sb_t sb_q[$];
    int  n_errors;
    int  n_checks;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NTW-1:0] model_tid(input logic [NT-1:0] m);
        for (int t = NT - 1; t >= 0; t--) begin
            if (m[t]) return NTW'(t);
        end
        return '0;
    endfunction

    function automatic logic [OW-1:0] out_dat(input int u);
        return out_data[u*OW +: OW];
    endfunction

    function automatic logic [CW-1:0] out_cnt(input int u);
        return out_count[u*CW +: CW];
    endfunction

    task automatic drive(input int i, input logic v, input logic [DW-1:0] d,
                         input logic [NT-1:0] m, input int u);
        in_valid[i]              = v;
        in_data[i*DW +: DW]      = d;
        in_tmask[i*NT +: NT]     = m;
        in_ex_type[i*EXW +: EXW] = EXW'(u);
    endtask

    task automatic idle_all();
        in_valid   = '0;
        in_data    = '0;
        in_tmask   = '0;
        in_ex_type = '0;
    endtask

    // Records the transfers that the coming rising edge will perform.
    task automatic sb_eval();
        sb_t e;
        int  found;
        for (int i = 0; i < NI; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                e.unit = int'(in_ex_type[i*EXW +: EXW]);
                e.dat  = {in_data[i*DW +: DW], model_tid(in_tmask[i*NT +: NT])};
                sb_q.push_back(e);
            end
        end
        for (int u = 0; u < NU; u++) begin
            if (out_valid[u] && out_ready[u]) begin
                found = -1;
                for (int k = 0; k < sb_q.size(); k++) begin
                    if (found < 0 && sb_q[k].unit == u) found = k;
                end
                check("sb_entry_expected", 128'(found >= 0), 128'(1));
                if (found >= 0) begin
                    check("sb_pop_data", 128'(out_dat(u)), 128'(sb_q[found].dat));
                    sb_q.delete(found);
                end
            end
        end
    endtask

    task automatic tick();
        sb_eval();
        @(negedge clk);
    endtask

    int   n0;
    int   n1;
    logic expg;

    initial begin
        n_errors  = 0;
        n_checks  = 0;
        reset     = 1'b1;
        out_ready = '1;
        idle_all();
        drive(0, 1'b1, 64'h5, 4'b0001, 0);
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_count", 128'(out_count), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
`ifdef DISPATCH_PERF_EN
        check("rst_perf", 128'(perf_stalls[127:0]), 128'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_all();

        // Single transfer to unit 2, visible one cycle later
        drive(0, 1'b1, 64'h11, 4'b0110, 2);
        #1;
        check("t1_in_ready", 128'(in_ready), 128'(2'b01));
        check("t1_no_bypass", 128'(out_valid), 128'(0));
        tick();
        idle_all();
        #1;
        check("t1_out_valid", 128'(out_valid), 128'(4'b0100));
        check("t1_out_data", 128'(out_dat(2)), 128'({64'h11, 2'd2}));
        check("t1_count", 128'(out_cnt(2)), 128'(1));
        tick();

        // Contention on unit 1: grants alternate starting from input 0
        n0   = 0;
        n1   = 0;
        expg = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 64'hA0 + 64'(n0), 4'b1000, 1);
            drive(1, 1'b1, 64'hB0 + 64'(n1), 4'b0001, 1);
            #1;
            check("t2_grant", 128'(in_ready), expg ? 128'(2'b10) : 128'(2'b01));
            if (expg) n1++;
            else n0++;
            expg = ~expg;
            tick();
        end
        idle_all();
        #1;
        tick();
        #1;
        check("t2_drained", 128'(out_valid), 128'(0));
        tick();

        // Full FIFO on unit 0: third push held until a pop frees a slot
        out_ready = 4'b1110;
        drive(0, 1'b1, 64'hC0, 4'b0011, 0);
        #1;
        check("t3_push0_rdy", 128'(in_ready), 128'(2'b01));
        tick();
        drive(0, 1'b1, 64'hC1, 4'b0100, 0);
        #1;
        check("t3_push1_rdy", 128'(in_ready), 128'(2'b01));
        tick();
        drive(0, 1'b1, 64'hC2, 4'b1111, 0);
        #1;
        check("t3_full_count", 128'(out_cnt(0)), 128'(2));
        check("t3_full_hold", 128'(in_ready), 128'(0));
        check("t3_head", 128'(out_dat(0)), 128'({64'hC0, 2'd1}));
        tick();
        #1;
        check("t3_head_stable", 128'(out_dat(0)), 128'({64'hC0, 2'd1}));
        check("t3_still_held", 128'(in_ready), 128'(0));
        tick();
        out_ready = 4'b1111;
        #1;
        check("t3_pop_no_push", 128'(in_ready), 128'(0));
        tick();
        #1;
        check("t3_enter", 128'(in_ready), 128'(2'b01));
        check("t3_count_after_pop", 128'(out_cnt(0)), 128'(1));
        tick();
        idle_all();
        #1;
        check("t3_push_pop_same", 128'(out_cnt(0)), 128'(1));
        check("t3_head_c2", 128'(out_dat(0)), 128'({64'hC2, 2'd3}));
        tick();

        // Zero mask and independent units accepted together
        drive(0, 1'b1, 64'hD0, 4'b1000, 0);
        drive(1, 1'b1, 64'h33, 4'b0000, 3);
        #1;
        check("t4_parallel_rdy", 128'(in_ready), 128'(2'b11));
        tick();
        drive(1, 1'b1, 64'h34, 4'b1000, 3);
        in_valid[0] = 1'b0;
        #1;
        check("t4_out_valid", 128'(out_valid), 128'(4'b1001));
        check("t4_zero_mask", 128'(out_dat(3)), 128'({64'h33, 2'd0}));
        check("t4_unit0_data", 128'(out_dat(0)), 128'({64'hD0, 2'd3}));
        tick();
        idle_all();
        #1;
        check("t4_mask_1000", 128'(out_dat(3)), 128'({64'h34, 2'd3}));
        tick();

        // Asynchronous reset with two entries buffered in unit 3
        out_ready = 4'b0111;
        drive(0, 1'b1, 64'hE0, 4'b0001, 3);
        #1;
        check("t5_push0", 128'(in_ready), 128'(2'b01));
        tick();
        in_valid[0] = 1'b0;
        drive(1, 1'b1, 64'hE1, 4'b0010, 3);
        #1;
        check("t5_push1", 128'(in_ready), 128'(2'b10));
        tick();
        idle_all();
        #1;
        check("t5_count_before", 128'(out_cnt(3)), 128'(2));
        sb_eval();
        #2;
        drive(0, 1'b1, 64'hE2, 4'b0001, 3);
        reset = 1'b1;
        #1;
        check("t5_rst_valid", 128'(out_valid), 128'(0));
        check("t5_rst_count", 128'(out_count), 128'(0));
        check("t5_rst_in_ready", 128'(in_ready), 128'(0));
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        idle_all();

        // Unit 0 held full while a request waits for 5 cycles
        out_ready = 4'b1110;
        drive(0, 1'b1, 64'hF0, 4'b0001, 0);
        #1;
        check("t6_push0", 128'(in_ready), 128'(2'b01));
        tick();
        drive(0, 1'b1, 64'hF1, 4'b0001, 0);
        #1;
        check("t6_push1", 128'(in_ready), 128'(2'b01));
        tick();
        drive(0, 1'b1, 64'hF2, 4'b0001, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t6_stall_rdy", 128'(in_ready), 128'(0));
            tick();
        end
        idle_all();
        #1;
`ifdef DISPATCH_PERF_EN
        check("t6_perf_u0", 128'(perf_stalls[0*PCB +: PCB]), 128'(5));
        for (int u = 1; u < NU; u++) begin
            check("t6_perf_other", 128'(perf_stalls[u*PCB +: PCB]), 128'(0));
        end
`endif
        check("t6_count_full", 128'(out_cnt(0)), 128'(2));
        out_ready = 4'b1111;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            tick();
        end
        #1;
        check("end_count", 128'(out_count), 128'(0));
        check("end_sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
